// File: rtl/dma_scheduler_pkg.sv
// Shared types for the frame-synchronous DMA scheduler:
// FSM state encodings and the memory data width.
package dma_scheduler_pkg;

    localparam int DMA_DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HALT_REQ  = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RELEASE   = 3'd5
    } state_e;

endpackage

// File: rtl/dma_scheduler_if.sv
// Bundle of CPU, DMA-client and data-memory write-port signals around the scheduler.
// master: scheduler side. slave: CPU/clients/memory side.
interface dma_scheduler_if #(
    parameter int CLIENT_COUNT = 2,
    parameter int ADDR_WIDTH   = 13
);
    localparam int DW = dma_scheduler_pkg::DMA_DATA_WIDTH;

    logic                          frame_tick;
    logic                          cpu_halt;
    logic                          cpu_halted;
    logic                          cpu_we;
    logic [ADDR_WIDTH-1:0]         cpu_addr;
    logic [DW-1:0]                 cpu_dout;
    logic [CLIENT_COUNT-1:0]       cl_start;
    logic [CLIENT_COUNT-1:0]       cl_we;
    logic [CLIENT_COUNT*ADDR_WIDTH-1:0] cl_addr;
    logic [CLIENT_COUNT*DW-1:0]    cl_dout;
    logic                          mem_we;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DW-1:0]                 mem_din;
    logic                          seq_done;
    logic                          overrun;
    logic [CLIENT_COUNT-1:0]       cl_err;

    modport master (
        input  frame_tick, cpu_halted, cpu_we, cpu_addr, cpu_dout,
        input  cl_we, cl_addr, cl_dout,
        output cpu_halt, cl_start, mem_we, mem_addr, mem_din,
        output seq_done, overrun, cl_err
    );

    modport slave (
        output frame_tick, cpu_halted, cpu_we, cpu_addr, cpu_dout,
        output cl_we, cl_addr, cl_dout,
        input  cpu_halt, cl_start, mem_we, mem_addr, mem_din,
        input  seq_done, overrun, cl_err
    );

endinterface

// File: rtl/dma_port_mux.sv
// Combinational owner select for the data-memory write port.
// Ports: grant/idx pick client idx, otherwise the CPU; packed client buses in, mem_* out.
module dma_port_mux
    import dma_scheduler_pkg::*;
#(
    parameter int CLIENT_COUNT = 2,
    parameter int ADDR_WIDTH   = 13,
    parameter int IDX_WIDTH    = 1
) (
    input  logic                               grant,
    input  logic [IDX_WIDTH-1:0]               idx,
    input  logic                               cpu_we,
    input  logic [ADDR_WIDTH-1:0]              cpu_addr,
    input  logic [DMA_DATA_WIDTH-1:0]          cpu_dout,
    input  logic [CLIENT_COUNT-1:0]            cl_we,
    input  logic [CLIENT_COUNT*ADDR_WIDTH-1:0] cl_addr,
    input  logic [CLIENT_COUNT*DMA_DATA_WIDTH-1:0] cl_dout,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic [DMA_DATA_WIDTH-1:0]          mem_din
);

    always_comb begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_din  = cpu_dout;
        if (grant) begin
            // Only the granted client reaches memory; cpu_we is blocked.
            mem_we   = cl_we[idx];
            mem_addr = cl_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_din  = cl_dout[int'(idx)*DMA_DATA_WIDTH +: DMA_DATA_WIDTH];
        end
    end

endmodule

// File: rtl/dma_scheduler.sv
// Frame-synchronous data-memory write-port sequencer: halts the CPU on frame_tick,
// starts each DMA client in index order, muxes its writes to memory, then releases the CPU.
// Ports: clk, reset (async, active-high), bus (dma_scheduler_if.master).
// Optional per-client watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_scheduler
    import dma_scheduler_pkg::*;
#(
    parameter int CLIENT_COUNT = 2,
    parameter int ADDR_WIDTH   = 13
`ifdef DMA_TIMEOUT_EN
    ,
    parameter int TIMEOUT      = 1024
`endif
) (
    input  logic            clk,
    input  logic            reset,
    dma_scheduler_if.master bus
);

    localparam int IW = (CLIENT_COUNT > 1) ? $clog2(CLIENT_COUNT) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cpu_halt_q, cpu_halt_d;
    logic          overrun_q, overrun_d;
    logic          last;
    logic          grant;
    logic          tmo;
    logic          adv;

`ifdef DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0]           timer_q, timer_d;
    logic [CLIENT_COUNT-1:0] cl_err_q, cl_err_d;
    assign tmo = (timer_q == TW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    assign last  = (idx_q == IW'(CLIENT_COUNT - 1));
    assign grant = (state_q == S_START) || (state_q == S_WAIT_BUSY) ||
                   (state_q == S_WAIT_DONE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        adv       = 1'b0;
        overrun_d = overrun_q | (bus.frame_tick & (state_q != S_IDLE));
`ifdef DMA_TIMEOUT_EN
        timer_d   = timer_q;
        cl_err_d  = cl_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_tick) state_d = S_HALT_REQ;
            end
            S_HALT_REQ: begin
                if (bus.cpu_halted) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
`ifdef DMA_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            S_WAIT_BUSY: begin
                // A timeout wins over a late busy indication.
                if (tmo) adv = 1'b1;
                else if (bus.cl_we[idx_q]) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tmo || !bus.cl_we[idx_q]) adv = 1'b1;
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DMA_TIMEOUT_EN
        if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
            timer_d = timer_q + 1'b1;
            if (tmo) cl_err_d[idx_q] = 1'b1;
        end
`endif

        if (adv) begin
            if (last) begin
                state_d = S_RELEASE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_START;
            end
        end

        cpu_halt_d = (state_d == S_HALT_REQ) || (state_d == S_START) ||
                     (state_d == S_WAIT_BUSY) || (state_d == S_WAIT_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cpu_halt_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cpu_halt_q <= cpu_halt_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef DMA_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q  <= '0;
            cl_err_q <= '0;
        end else begin
            timer_q  <= timer_d;
            cl_err_q <= cl_err_d;
        end
    end
    assign bus.cl_err = cl_err_q;
`else
    assign bus.cl_err = '0;
`endif

    assign bus.cpu_halt = cpu_halt_q;
    assign bus.cl_start = (state_q == S_START) ?
                          (CLIENT_COUNT'(1) << idx_q) : '0;
    assign bus.seq_done = (state_q == S_RELEASE);
    assign bus.overrun  = overrun_q;

    dma_port_mux #(
        .CLIENT_COUNT(CLIENT_COUNT),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .IDX_WIDTH   (IW)
    ) u_mux (
        .grant   (grant),
        .idx     (idx_q),
        .cpu_we  (bus.cpu_we),
        .cpu_addr(bus.cpu_addr),
        .cpu_dout(bus.cpu_dout),
        .cl_we   (bus.cl_we),
        .cl_addr (bus.cl_addr),
        .cl_dout (bus.cl_dout),
        .mem_we  (bus.mem_we),
        .mem_addr(bus.mem_addr),
        .mem_din (bus.mem_din)
    );

endmodule
